// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite types for the memory slave: transfer/response encodings,
// the slave FSM state set and the wait-counter width.
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } HTRANS_state;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } HRESP_state;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } slave_state;

  // Wait counter width; wait parameters are limited to 0..15.
  localparam int WAIT_W = 4;

endpackage

// File: rtl/ahb3lite_lane_dec.sv
// Combinational byte-lane and alignment decode for one AHB transfer.
// be marks 2^size consecutive little-endian lanes starting at the lane
// selected by the low address bits; size_ok rejects transfers wider than
// the bus, aligned rejects addresses not on a 2^size boundary.
module ahb3lite_lane_dec #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]             addr,
  input  logic [2:0]              size,
  output logic [DATA_WIDTH/8-1:0] be,
  output logic                    size_ok,
  output logic                    aligned
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int LW = $clog2(NB);
  localparam logic [2:0] MAX_SIZE = 3'(LW);

  logic [31:0] align_mask;
  logic [8:0]  lane_lo;
  logic [8:0]  nbytes;

  assign size_ok    = (size <= MAX_SIZE);
  assign align_mask = (32'd1 << size) - 32'd1;
  assign aligned    = ((addr & align_mask) == 32'd0);
  assign lane_lo    = 9'(addr[LW-1:0]);
  assign nbytes     = 9'd1 << size;

  // A lane is enabled when its offset from the start lane is below the
  // transfer byte count; lanes below the start wrap to a large offset.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign be[gi] = size_ok && ((9'(gi) - lane_lo) < nbytes);
    end
  endgenerate

endmodule

// File: rtl/ahb3lite_mem_slave.sv
// AHB3-Lite slave fronting a byte-addressed memory with combinational read.
// Legal beats insert a configurable number of wait states (NONSEQ vs SEQ),
// then complete in a single data cycle that strobes the memory. Out-of-range,
// oversize or misaligned beats get a two-cycle ERROR response instead.
module ahb3lite_mem_slave
  import ahb3lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_BYTES  = 4096,
  parameter int NSEQ_WAIT  = 2,
  parameter int SEQ_WAIT   = 0
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic                         HSEL,
  input  logic                         HREADY,
  input  logic [31:0]                  HADDR,
  input  HTRANS_state                  HTRANS,
  input  logic [2:0]                   HSIZE,
  input  logic                         HWRITE,
  input  logic [DATA_WIDTH-1:0]        HWDATA,
  output logic                         HREADYOUT,
  output HRESP_state                   HRESP,
  output logic [DATA_WIDTH-1:0]        HRDATA,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [DATA_WIDTH/8-1:0]      mem_be,
  output logic [$clog2(MEM_BYTES)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  input  logic [DATA_WIDTH-1:0]        mem_rdata
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [WAIT_W-1:0] NSEQ_WAIT_C = WAIT_W'(NSEQ_WAIT);
  localparam logic [WAIT_W-1:0] SEQ_WAIT_C  = WAIT_W'(SEQ_WAIT);

  slave_state        state_reg, state_next;
  logic [31:0]       addr_reg;
  logic [2:0]        size_reg;
  logic              write_reg;
  HTRANS_state       trans_reg;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;

  logic              in_window, accept, in_range, in_legal;
  logic              in_size_ok, in_aligned;
  logic [NB-1:0]     in_be;
  logic [NB-1:0]     q_be;
  logic              q_size_ok, q_aligned;
  logic [WAIT_W-1:0] accept_wait, wait_limit;
  logic              unused_dec;

  // Legality of the beat being offered, needed to pick ERR1 at accept time.
  ahb3lite_lane_dec #(.DATA_WIDTH(DATA_WIDTH)) u_dec_in (
    .addr    (HADDR),
    .size    (HSIZE),
    .be      (in_be),
    .size_ok (in_size_ok),
    .aligned (in_aligned)
  );

  // Byte lanes of the registered beat, driven to memory in the data cycle.
  ahb3lite_lane_dec #(.DATA_WIDTH(DATA_WIDTH)) u_dec_q (
    .addr    (addr_reg),
    .size    (size_reg),
    .be      (q_be),
    .size_ok (q_size_ok),
    .aligned (q_aligned)
  );

  assign unused_dec = ^{in_be, q_size_ok, q_aligned};

  // Address phases are only taken when the previous beat is finishing.
  assign in_window   = (state_reg == S_IDLE) || (state_reg == S_DATA) ||
                       (state_reg == S_ERR2);
  assign accept      = HSEL && HREADY && in_window &&
                       ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign in_range    = (HADDR[31:AW] == '0);
  assign in_legal    = in_range && in_size_ok && in_aligned;
  assign accept_wait = (HTRANS == HTRANS_SEQ) ? SEQ_WAIT_C : NSEQ_WAIT_C;
  assign wait_limit  = (trans_reg == HTRANS_SEQ) ? SEQ_WAIT_C : NSEQ_WAIT_C;

  // State, wait counter and address-phase capture.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= '0;
      addr_reg     <= '0;
      size_reg     <= '0;
      write_reg    <= 1'b0;
      trans_reg    <= HTRANS_IDLE;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (accept) begin
        addr_reg  <= HADDR;
        size_reg  <= HSIZE;
        write_reg <= HWRITE;
        trans_reg <= HTRANS;
      end
    end
  end

  // Next state: wait counts up to the beat's limit; windowed states pipeline.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      S_WAIT: begin
        if (wait_cnt_reg == wait_limit - WAIT_W'(1)) begin
          state_next = S_DATA;
        end else begin
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
      end
      S_ERR1: state_next = S_ERR2;
      default: begin
        if (accept) begin
          wait_cnt_next = '0;
          if (!in_legal) begin
            state_next = S_ERR1;
          end else if (accept_wait != '0) begin
            state_next = S_WAIT;
          end else begin
            state_next = S_DATA;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
    endcase
  end

  // Bus response and memory strobes decoded from the current state.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    case (state_reg)
      S_WAIT: HREADYOUT = 1'b0;
      S_DATA: begin
        mem_en = 1'b1;
        mem_we = write_reg;
        mem_be = q_be;
        if (!write_reg) HRDATA = mem_rdata;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      S_ERR2: HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

  assign mem_addr  = addr_reg[AW-1:0];
  assign mem_wdata = HWDATA;

endmodule

// File: tb/tb_ahb3lite_mem_slave.sv
// Directed bench for ahb3lite_mem_slave: a 32-bit and a 64-bit instance share
// one byte memory model. Beats and their expected results are queued, then
// driven with AHB pipelining and compared as each data phase completes.
module tb_ahb3lite_mem_slave;
  import ahb3lite_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, hsel, use64;
  logic [31:0] haddr;
  HTRANS_state htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [63:0] hwdata;

  logic        rdy32, en32, we32;
  HRESP_state  resp32;
  logic [31:0] rdata32, wd32, mrd32;
  logic [3:0]  be32;
  logic [11:0] addr32;

  logic        rdy64, en64, we64;
  HRESP_state  resp64;
  logic [63:0] rdata64, wd64, mrd64;
  logic [7:0]  be64;
  logic [11:0] addr64;

  ahb3lite_mem_slave #(.DATA_WIDTH(32), .MEM_BYTES(4096), .NSEQ_WAIT(2), .SEQ_WAIT(0)) u_dut32 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel && !use64), .HREADY(rdy32),
    .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite),
    .HWDATA(hwdata[31:0]), .HREADYOUT(rdy32), .HRESP(resp32), .HRDATA(rdata32),
    .mem_en(en32), .mem_we(we32), .mem_be(be32), .mem_addr(addr32),
    .mem_wdata(wd32), .mem_rdata(mrd32)
  );

  ahb3lite_mem_slave #(.DATA_WIDTH(64), .MEM_BYTES(4096), .NSEQ_WAIT(2), .SEQ_WAIT(0)) u_dut64 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel && use64), .HREADY(rdy64),
    .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite),
    .HWDATA(hwdata), .HREADYOUT(rdy64), .HRESP(resp64), .HRDATA(rdata64),
    .mem_en(en64), .mem_we(we64), .mem_be(be64), .mem_addr(addr64),
    .mem_wdata(wd64), .mem_rdata(mrd64)
  );

  // Byte memory: preload pattern addr^0x5A, then apply strobed writes.
  logic [7:0] mem [4096];
  int we_pulses = 0;
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5A;
    forever begin
      @(posedge clk);
      if (en32 && we32) begin
        we_pulses++;
        for (int b = 0; b < 4; b++)
          if (be32[b]) mem[int'({addr32[11:2], 2'b00}) + b] = wd32[8*b +: 8];
      end
      if (en64 && we64) begin
        we_pulses++;
        for (int b = 0; b < 8; b++)
          if (be64[b]) mem[int'({addr64[11:3], 3'b000}) + b] = wd64[8*b +: 8];
      end
    end
  end

  always_comb begin
    mrd32 = '0;
    mrd64 = '0;
    for (int b = 0; b < 4; b++) mrd32[8*b +: 8] = mem[int'({addr32[11:2], 2'b00}) + b];
    for (int b = 0; b < 8; b++) mrd64[8*b +: 8] = mem[int'({addr64[11:3], 3'b000}) + b];
  end

  // Observed outputs of whichever instance is under test.
  logic        obs_rdy, obs_en, obs_we;
  HRESP_state  obs_resp;
  logic [7:0]  obs_be;
  logic [11:0] obs_addr;
  logic [63:0] obs_rdata;
  always_comb begin
    if (use64) begin
      obs_rdy = rdy64; obs_resp = resp64; obs_en = en64; obs_we = we64;
      obs_be = be64; obs_addr = addr64; obs_rdata = rdata64;
    end else begin
      obs_rdy = rdy32; obs_resp = resp32; obs_en = en32; obs_we = we32;
      obs_be = {4'd0, be32}; obs_addr = addr32; obs_rdata = {32'd0, rdata32};
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
    HTRANS_state trans;
    logic [63:0] wdata;
  } beat_t;

  typedef struct {
    string       tag;
    int          cycles;
    logic        err;
    logic [7:0]  be;
    logic [11:0] addr;
    logic        wr;
    logic [63:0] rdata;
  } exp_t;

  beat_t beat_q[$];
  exp_t  exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_beat(input string tag, input logic [31:0] a, input logic [2:0] sz,
                           input logic wr, input HTRANS_state tr, input logic [63:0] wd,
                           input int cyc, input logic err, input logic [7:0] be,
                           input logic [63:0] rd);
    beat_t b;
    exp_t  e;
    b.addr = a; b.size = sz; b.wr = wr; b.trans = tr; b.wdata = wd;
    e.tag = tag; e.cycles = cyc; e.err = err; e.be = be; e.addr = a[11:0];
    e.wr = wr; e.rdata = rd;
    beat_q.push_back(b);
    exp_q.push_back(e);
  endtask

  task automatic drive_addr(input beat_t b);
    hsel = 1'b1; haddr = b.addr; hsize = b.size; hwrite = b.wr; htrans = b.trans;
  endtask

  // Drive all queued beats back-to-back; each next address phase overlaps
  // the current data phase and is held until the slave is ready.
  task automatic run_beats();
    beat_t      b;
    exp_t       e;
    int         n, cyc;
    logic       en_wait;
    HRESP_state resp_first;
    n = beat_q.size();
    @(posedge clk); #1;
    drive_addr(beat_q[0]);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      b = beat_q.pop_front();
      hwdata = b.wdata;
      if (beat_q.size() > 0) drive_addr(beat_q[0]);
      else htrans = HTRANS_IDLE;
      cyc = 0; en_wait = 1'b0; resp_first = HRESP_OKAY;
      do begin
        @(negedge clk);
        cyc++;
        if (cyc == 1) resp_first = obs_resp;
        if (!obs_rdy) en_wait = en_wait | obs_en;
      end while (!obs_rdy && cyc < 40);
      e = exp_q.pop_front();
      check({e.tag, ".cycles"}, 64'(cyc), 64'(e.cycles));
      check({e.tag, ".resp_first"}, 64'(resp_first), 64'(e.err ? HRESP_ERROR : HRESP_OKAY));
      check({e.tag, ".resp_last"}, 64'(obs_resp), 64'(e.err ? HRESP_ERROR : HRESP_OKAY));
      check({e.tag, ".en_wait"}, 64'(en_wait), 64'd0);
      check({e.tag, ".en"}, 64'(obs_en), 64'(!e.err));
      check({e.tag, ".we"}, 64'(obs_we), 64'(e.wr && !e.err));
      check({e.tag, ".be"}, 64'(obs_be), e.err ? 64'd0 : 64'(e.be));
      if (!e.err) check({e.tag, ".addr"}, 64'(obs_addr), 64'(e.addr));
      check({e.tag, ".rdata"}, obs_rdata, (e.wr || e.err) ? 64'd0 : e.rdata);
      $display("beat %s addr=%h cycles=%0d resp=%0d be=%h rdata=%h",
               e.tag, e.addr, cyc, obs_resp, obs_be, obs_rdata);
    end
  endtask

  initial begin
    int pulses_before;
    rst_n = 1'b0; hsel = 1'b0; use64 = 1'b0; haddr = '0; htrans = HTRANS_IDLE;
    hsize = 3'd0; hwrite = 1'b0; hwdata = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst.ready", 64'(obs_rdy), 64'd1);
    check("rst.resp", 64'(obs_resp), 64'(HRESP_OKAY));
    check("rst.rdata", obs_rdata, 64'd0);
    check("rst.en", 64'(obs_en), 64'd0);
    check("rst.we", 64'(obs_we), 64'd0);
    check("rst.be", 64'(obs_be), 64'd0);
    check("rst.addr", 64'(obs_addr), 64'd0);
    $display("reset checked");
    rst_n = 1'b1;

    // Selected IDLE/BUSY: zero-wait OKAY, no memory access.
    @(posedge clk); #1;
    hsel = 1'b1; htrans = HTRANS_BUSY; haddr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("busy.ready", 64'(obs_rdy), 64'd1);
      check("busy.en", 64'(obs_en), 64'd0);
    end
    htrans = HTRANS_IDLE;
    $display("busy/idle phases checked");

    push_beat("wr10", 32'h10, 3'd2, 1'b1, HTRANS_NONSEQ, 64'hA5A5_1234, 3, 1'b0, 8'h0F, 64'd0);
    push_beat("incr0", 32'h20, 3'd2, 1'b0, HTRANS_NONSEQ, 64'd0, 3, 1'b0, 8'h0F, 64'h7978_7B7A);
    push_beat("incr1", 32'h24, 3'd2, 1'b0, HTRANS_SEQ, 64'd0, 1, 1'b0, 8'h0F, 64'h7D7C_7F7E);
    push_beat("incr2", 32'h28, 3'd2, 1'b0, HTRANS_SEQ, 64'd0, 1, 1'b0, 8'h0F, 64'h7170_7372);
    push_beat("incr3", 32'h2C, 3'd2, 1'b0, HTRANS_SEQ, 64'd0, 1, 1'b0, 8'h0F, 64'h7574_7776);
    push_beat("rd1000", 32'h1000, 3'd2, 1'b0, HTRANS_NONSEQ, 64'd0, 2, 1'b1, 8'h00, 64'd0);
    push_beat("wrb7", 32'h7, 3'd0, 1'b1, HTRANS_NONSEQ, 64'hCC00_0000, 3, 1'b0, 8'h08, 64'd0);
    push_beat("wrh3", 32'h3, 3'd1, 1'b1, HTRANS_NONSEQ, 64'h1111_1111, 2, 1'b1, 8'h00, 64'd0);
    push_beat("rd4", 32'h4, 3'd2, 1'b0, HTRANS_NONSEQ, 64'd0, 3, 1'b0, 8'h0F, 64'hCC5C_5F5E);
    push_beat("dw32", 32'h0, 3'd3, 1'b0, HTRANS_NONSEQ, 64'd0, 2, 1'b1, 8'h00, 64'd0);
    push_beat("rd10", 32'h10, 3'd2, 1'b0, HTRANS_NONSEQ, 64'd0, 3, 1'b0, 8'h0F, 64'hA5A5_1234);
    push_beat("rdh12", 32'h12, 3'd1, 1'b0, HTRANS_SEQ, 64'd0, 1, 1'b0, 8'h0C, 64'hA5A5_1234);
    run_beats();

    // Reset in the middle of a write's wait states.
    pulses_before = we_pulses;
    @(posedge clk); #1;
    hsel = 1'b1; haddr = 32'h40; hsize = 3'd2; hwrite = 1'b1; htrans = HTRANS_NONSEQ;
    @(posedge clk); #1;
    htrans = HTRANS_IDLE; hwdata = 64'hDEAD_BEEF;
    @(negedge clk);
    check("rstwait.in_wait", 64'(obs_rdy), 64'd0);
    rst_n = 1'b0;
    #1;
    check("rstwait.ready", 64'(obs_rdy), 64'd1);
    check("rstwait.resp", 64'(obs_resp), 64'(HRESP_OKAY));
    check("rstwait.en", 64'(obs_en), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rstwait.no_write", 64'(we_pulses), 64'(pulses_before));
    $display("reset during wait checked");
    push_beat("rd40", 32'h40, 3'd2, 1'b0, HTRANS_NONSEQ, 64'd0, 3, 1'b0, 8'h0F, 64'h1918_1B1A);
    run_beats();

    // 64-bit instance.
    @(posedge clk); #1;
    use64 = 1'b1;
    push_beat("w64_8", 32'h8, 3'd3, 1'b1, HTRANS_NONSEQ, 64'h0123_4567_89AB_CDEF, 3, 1'b0, 8'hFF, 64'd0);
    push_beat("w64_4", 32'h4, 3'd3, 1'b1, HTRANS_NONSEQ, 64'd0, 2, 1'b1, 8'h00, 64'd0);
    push_beat("r64_8", 32'h8, 3'd3, 1'b0, HTRANS_NONSEQ, 64'd0, 3, 1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF);
    run_beats();

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
